pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DRAIN_CYC, default 3: cycles of bubble injection before interrupt entry; legal range 1..7.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 load_use  input  1  ID instruction depends on a load currently in EX.
REQ-006 branch_taken  input  1  EX resolved a taken branch or jump (redirect).
REQ-007 mem_busy  input  1  data memory is not ready; the whole pipeline must freeze.
REQ-008 int_req  input  1  level interrupt request.
REQ-009 halt_wb  input  1  a syscall-halt is in WB.
REQ-010 resume  input  1  single-cycle pulse that leaves the halted state.
REQ-011 pc_en  output  1  PC register update enable.
REQ-012 if_id_en, id_ex_en, ex_dm_en, dm_wb_en  output  1 each  pipeline register enables.
REQ-013 if_id_clr_n, id_ex_clr_n, ex_dm_clr_n, dm_wb_clr_n  output  1 each  active-low synchronous clear; 0 loads a bubble.
REQ-014 int_enter  output  1  one-cycle pulse that selects the interrupt vector into the PC.
REQ-015 halted  output  1  core is halted.
REQ-016 stall_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-017 States: RUN, INT_DRAIN, INT_ENTER, HALTED; 3-bit drain counter drain_q.
REQ-018 Outputs are combinational from state and inputs. Default in RUN: every en=1 and every clr_n=1.
REQ-019 Priority, highest first: halt_wb, then mem_busy, then interrupt sequencing, then branch_taken, then load_use.
REQ-020 halt_wb in any state: next state HALTED. In HALTED: pc_en=0, all en=0, halted=1. A resume pulse returns to RUN on the next edge.
REQ-021 mem_busy=1 (not HALTED): pc_en=0 and all en=0 in that same cycle. State and drain_q hold. No clr_n is asserted.
REQ-022 branch_taken in RUN or INT_DRAIN: if_id_clr_n=0 and id_ex_clr_n=0. pc_en stays 1 in RUN.
REQ-023 load_use in RUN with no branch_taken: pc_en=0, if_id_en=0 and id_ex_clr_n=0, giving exactly one bubble per asserted cycle.
REQ-024 branch_taken together with load_use: the branch rule applies and load_use is ignored.
REQ-025 int_req sampled in RUN with no halt_wb, mem_busy or load_use: next state INT_DRAIN and drain_q=0.
REQ-026 In INT_DRAIN: pc_en=0 and if_id_clr_n=0, so older instructions drain. drain_q increments each non-frozen cycle. At drain_q=DRAIN_CYC-1 the next state is INT_ENTER.
REQ-027 In INT_ENTER: int_enter=1, pc_en=1, if_id_clr_n=0. Next state RUN.
REQ-028 int_req is ignored outside RUN. A branch during INT_DRAIN does not restart drain_q.
REQ-029 Counters wrap modulo 2^CNT_W.
- stall_cnt +1 per cycle with pc_en=0 in RUN.
- flush_cnt +1 per cycle with branch flush.

Reset
REQ-030 While rst=1: state=RUN, drain_q=0, counters=0, all en=0, all clr_n=0, pc_en=0, int_enter=0, halted=0.
REQ-031 Reset asserted mid-INT_DRAIN or mid-HALTED aborts the sequence. The first cycle after release is plain RUN.

Configuration
REQ-032 Macro PIPE_CTRL_PERF_EN defined: stall_cnt and flush_cnt count per REQ-029.
REQ-033 PIPE_CTRL_PERF_EN undefined: the counters are not built, the ports remain present and are tied to 0.

Structure
REQ-034 Shared package pipe_ctrl_pkg holds the state enum, the state width constant and the DRAIN_CYC limit.
REQ-035 The counters live in sub-module pipe_ctrl_perf_cnt, which is instantiated only under PIPE_CTRL_PERF_EN.

Verification
REQ-036 load_use=1 for 1 cycle in RUN:
- that cycle: pc_en=0, if_id_en=0, id_ex_clr_n=0;
- next cycle: all en=1;
- stall_cnt=1.
REQ-037 branch_taken=1 with load_use=1 in the same cycle:
- if_id_clr_n=0, id_ex_clr_n=0, pc_en=1;
- flush_cnt=1, stall_cnt=0.
REQ-038 int_req=1 in RUN, DRAIN_CYC=3:
- 3 cycles INT_DRAIN with pc_en=0;
- then 1 cycle int_enter=1;
- then RUN.
REQ-039 mem_busy=1 for 4 cycles during INT_DRAIN at drain_q=1:
- all en=0 for those 4 cycles;
- drain_q holds at 1;
- int_enter arrives 2 cycles after mem_busy falls.
REQ-040 halt_wb=1 then resume after 10 cycles:
- halted=1 and all en=0 for 10 cycles;
- RUN on the edge after resume.
REQ-041 rst pulsed during INT_DRAIN:
- during rst: all outputs 0;
- after release: RUN, counters 0, no int_enter.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / interrupt controller.
package pipe_ctrl_pkg;

  localparam int STATE_W       = 2;
  localparam int DRAIN_W       = 3;
  localparam int DRAIN_CYC_MAX = 7;

  typedef enum logic [STATE_W-1:0] {
    RUN       = 2'd0,
    INT_DRAIN = 2'd1,
    INT_ENTER = 2'd2,
    HALTED    = 2'd3
  } state_t;

  // Last drain_q value before interrupt entry; out-of-range DRAIN_CYC is clamped to 1..7.
  function automatic logic [DRAIN_W-1:0] drain_last(input int cyc);
    int c;
    c = cyc;
    if (c < 1) c = 1;
    if (c > DRAIN_CYC_MAX) c = DRAIN_CYC_MAX;
    return DRAIN_W'(c - 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Stall / flush performance counters; both wrap modulo 2^CNT_W.
module pipe_ctrl_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Count one event per qualifying cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: load-use stalls, branch flushes, memory
// freeze, interrupt drain/entry and syscall halt.
// Optional counters are built only when PIPE_CTRL_PERF_EN is defined;
// otherwise stall_cnt / flush_cnt are tied to zero.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             int_req,
  input  logic             halt_wb,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_dm_en,
  output logic             dm_wb_en,
  output logic             if_id_clr_n,
  output logic             id_ex_clr_n,
  output logic             ex_dm_clr_n,
  output logic             dm_wb_clr_n,
  output logic             int_enter,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [DRAIN_W-1:0] DRAIN_LAST = drain_last(DRAIN_CYC);

  state_t             state, state_nxt;
  logic [DRAIN_W-1:0] drain_q, drain_nxt;

  // State and drain counter registers; reset aborts any interrupt or halt sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      drain_q <= '0;
    end else begin
      state   <= state_nxt;
      drain_q <= drain_nxt;
    end
  end

  // Next-state: halt beats everything, a frozen pipe holds, then interrupt sequencing.
  always_comb begin
    state_nxt = state;
    drain_nxt = drain_q;
    if (halt_wb) begin
      state_nxt = HALTED;
      drain_nxt = '0;
    end else if (state == HALTED) begin
      if (resume) state_nxt = RUN;
    end else if (!mem_busy) begin
      case (state)
        RUN: begin
          // A load-use stall defers the interrupt; it is re-sampled next cycle.
          if (int_req && !load_use) begin
            state_nxt = INT_DRAIN;
            drain_nxt = '0;
          end
        end
        INT_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_nxt = INT_ENTER;
            drain_nxt = '0;
          end else begin
            drain_nxt = drain_q + DRAIN_W'(1);
          end
        end
        INT_ENTER: state_nxt = RUN;
        default:   state_nxt = RUN;
      endcase
    end
  end

  // Output decode: combinational from state and the current hazard inputs.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_dm_en    = 1'b1;
    dm_wb_en    = 1'b1;
    if_id_clr_n = 1'b1;
    id_ex_clr_n = 1'b1;
    ex_dm_clr_n = 1'b1;
    dm_wb_clr_n = 1'b1;
    int_enter   = 1'b0;
    halted      = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_dm_en    = 1'b0;
      dm_wb_en    = 1'b0;
      if_id_clr_n = 1'b0;
      id_ex_clr_n = 1'b0;
      ex_dm_clr_n = 1'b0;
      dm_wb_clr_n = 1'b0;
    end else if (halt_wb || state == HALTED || mem_busy) begin
      // Whole pipe frozen: nothing advances, nothing is cleared.
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_ex_en = 1'b0;
      ex_dm_en = 1'b0;
      dm_wb_en = 1'b0;
      halted   = (state == HALTED);
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            if_id_clr_n = 1'b0;
            id_ex_clr_n = 1'b0;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_clr_n = 1'b0;
          end
        end
        INT_DRAIN: begin
          pc_en       = 1'b0;
          if_id_clr_n = 1'b0;
          if (branch_taken) id_ex_clr_n = 1'b0;
        end
        INT_ENTER: begin
          int_enter   = 1'b1;
          if_id_clr_n = 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic stall_ev, flush_ev;

  // Stall: PC held while in RUN. Flush: a branch actually squashed IF/ID and ID/EX.
  assign stall_ev = !rst && (state == RUN) && !pc_en;
  assign flush_ev = !rst && !halt_wb && !mem_busy && branch_taken &&
                    (state == RUN || state == INT_DRAIN);

  pipe_ctrl_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall_ev),
    .flush     (flush_ev),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver issues one input vector per cycle
// and queues the predicted outputs; a monitor checks them mid-cycle.
module tb_pipe_ctrl;

  localparam int DRAIN_CYC = 3;
  localparam int CNT_W     = 4;   // small so the random run wraps the counters

  localparam int M_RUN = 0, M_DRAIN = 1, M_ENTER = 2, M_HALT = 3;

  typedef struct packed {
    logic [10:0]      ctrl;   // pc_en, en[4], clr_n[4], int_enter, halted
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_use = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;
  logic int_req = 1'b0, halt_wb = 1'b0, resume = 1'b0;
  logic pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en;
  logic if_id_clr_n, id_ex_clr_n, ex_dm_clr_n, dm_wb_clr_n;
  logic int_enter, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_ctrl #(.DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .load_use(load_use), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .int_req(int_req), .halt_wb(halt_wb), .resume(resume),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_dm_en(ex_dm_en),
    .dm_wb_en(dm_wb_en), .if_id_clr_n(if_id_clr_n), .id_ex_clr_n(id_ex_clr_n),
    .ex_dm_clr_n(ex_dm_clr_n), .dm_wb_clr_n(dm_wb_clr_n), .int_enter(int_enter),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: mode, completed drain cycles, and event tallies.
  int m_mode   = M_RUN;
  int m_done   = 0;
  int m_stalls = 0;
  int m_flush  = 0;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // One clock cycle of stimulus: drive, predict, then advance the model.
  task automatic cyc(input bit r, input bit lu, input bit br, input bit mb,
                     input bit ir, input bit hw, input bit rs);
    exp_t e;
    bit   pc, ie, hl, frozen, fl;
    bit [3:0] en, cl;
    @(posedge clk);
    #2;
    rst = r; load_use = lu; branch_taken = br; mem_busy = mb;
    int_req = ir; halt_wb = hw; resume = rs;

    pc = 1; en = 4'hF; cl = 4'hF; ie = 0; hl = 0; fl = 0;
    frozen = hw || mb || (m_mode == M_HALT);
    if (r) begin
      m_mode = M_RUN; m_done = 0; m_stalls = 0; m_flush = 0;
      pc = 0; en = 0; cl = 0;
    end else if (frozen) begin
      pc = 0; en = 0; hl = (m_mode == M_HALT);
    end else begin
      fl = br && (m_mode == M_RUN || m_mode == M_DRAIN);
      if (m_mode == M_DRAIN) begin pc = 0; cl[3] = 0; end
      if (m_mode == M_ENTER) begin ie = 1; cl[3] = 0; end
      if (fl) begin
        cl[3] = 0; cl[2] = 0;
      end else if (lu && m_mode == M_RUN) begin
        pc = 0; en[3] = 0; cl[2] = 0;
      end
    end
    e.ctrl = {pc, en, cl, ie, hl};
`ifdef PIPE_CTRL_PERF_EN
    e.stall = CNT_W'(m_stalls);
    e.flush = CNT_W'(m_flush);
`else
    e.stall = '0;
    e.flush = '0;
`endif
    q.push_back(e);

    if (!r) begin
      if (m_mode == M_RUN && !pc) m_stalls++;
      if (fl) m_flush++;
      if (hw) begin
        m_mode = M_HALT; m_done = 0;
      end else if (m_mode == M_HALT) begin
        if (rs) m_mode = M_RUN;
      end else if (!mb) begin
        if (m_mode == M_RUN) begin
          if (ir && !lu) begin m_mode = M_DRAIN; m_done = 0; end
        end else if (m_mode == M_DRAIN) begin
          m_done++;
          if (m_done == DRAIN_CYC) begin m_mode = M_ENTER; m_done = 0; end
        end else begin
          m_mode = M_RUN;
        end
      end
    end
  endtask

  // Monitor: outputs are combinational, so one record is due every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ctrl", 16'({pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en,
                         if_id_clr_n, id_ex_clr_n, ex_dm_clr_n, dm_wb_clr_n,
                         int_enter, halted}), 16'(e.ctrl));
        chk("stall_cnt", 16'(stall_cnt), 16'(e.stall));
        chk("flush_cnt", 16'(flush_cnt), 16'(e.flush));
      end
    end
  end

  initial begin
    // Reset state
    cyc(1,0,0,0,0,0,0); cyc(1,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0);
    // Single load-use bubble, then free flow
    cyc(0,1,0,0,0,0,0); cyc(0,0,0,0,0,0,0); cyc(0,0,0,0,0,0,0);
    // Branch with load-use: branch wins
    cyc(1,0,0,0,0,0,0);
    cyc(0,1,1,0,0,0,0); cyc(0,0,0,0,0,0,0); cyc(0,0,0,0,0,0,0);
    // Interrupt: three drain cycles, one entry cycle, then RUN
    cyc(0,0,0,0,1,0,0);
    for (int i = 0; i < 5; i++) cyc(0,0,0,0,0,0,0);
    // Interrupt with 4-cycle memory freeze at the second drain cycle, branch mid-drain
    cyc(0,0,0,0,1,0,0); cyc(0,0,0,0,0,0,0);
    for (int i = 0; i < 4; i++) cyc(0,0,0,1,1,0,0);
    cyc(0,0,1,0,0,0,0);
    for (int i = 0; i < 3; i++) cyc(0,0,0,0,0,0,0);
    // Halt, 10 cycles halted, resume
    cyc(0,0,0,0,0,1,0);
    for (int i = 0; i < 9; i++) cyc(0,1,1,1,1,0,0);
    cyc(0,0,0,0,0,0,1); cyc(0,0,0,0,0,0,0);
    // Reset pulsed mid-drain aborts the interrupt
    cyc(0,0,0,0,1,0,0); cyc(0,0,0,0,0,0,0);
    cyc(1,0,0,0,1,0,0); cyc(1,0,0,0,0,0,0);
    for (int i = 0; i < 5; i++) cyc(0,0,0,0,0,0,0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 1,
          $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 15);
    end
    @(negedge clk);
    #1;
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
